// File: rtl/riscy_pkg.sv
// +----------------------------------------------------------------------------+
// | Module   : riscy_pkg                                                       |
// | Brief    : Shared types and constants for the fetch stage.                 |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

package riscy_pkg;

   typedef logic [31:0] addr_t;
   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } fetch_state_t;

   localparam word_t C_HALT_WORD = 32'hFFFF_FFFF;

endpackage : riscy_pkg

`default_nettype wire

// File: rtl/fetch_unit_if.sv
// +----------------------------------------------------------------------------+
// | Module   : fetch_unit_if                                                   |
// | Brief    : ROM bus plus valid/ready instruction channel toward decode.     |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

interface fetch_unit_if #(
   parameter int AWIDTH = 32,
   parameter int DWIDTH = 32
);

   logic [AWIDTH-1:0] rom_addr;
   logic              rom_cs;
   logic              rom_oe;
   logic [DWIDTH-1:0] rom_data;
   logic [DWIDTH-1:0] instr;
   logic [AWIDTH-1:0] instr_pc;
   logic              valid;
   logic              ready;

   modport master (
      output rom_addr, rom_cs, rom_oe, instr, instr_pc, valid,
      input  rom_data, ready
   );

   modport slave (
      input  rom_addr, rom_cs, rom_oe, instr, instr_pc, valid,
      output rom_data, ready
   );

endinterface : fetch_unit_if

`default_nettype wire

// File: rtl/fetch_unit.sv
// +----------------------------------------------------------------------------+
// | Module   : fetch_unit                                                      |
// | Brief    : PC owner and ROM driver; registers words out to decode.         |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module fetch_unit
   import riscy_pkg::*;
#(
   parameter int                 AWIDTH    = 32,
   parameter int                 DWIDTH    = 32,
   parameter logic [AWIDTH-1:0]  RESET_PC  = '0,
   parameter logic [AWIDTH-1:0]  PC_INC    = 1,
   parameter logic [DWIDTH-1:0]  HALT_WORD = DWIDTH'(C_HALT_WORD)
) (
   input  wire logic              clk,
   input  wire logic              rst,
   input  wire logic              en,
   input  wire logic              redirect,
   input  wire logic [AWIDTH-1:0] redirect_pc,
   fetch_unit_if.master           bus,
   output logic                   halted,
   output logic [31:0]            fetch_cnt
);

   fetch_state_t       r_state;
   fetch_state_t       w_state_nxt;
   logic [AWIDTH-1:0]  r_pc;
   logic [DWIDTH-1:0]  r_instr;
   logic [AWIDTH-1:0]  r_instr_pc;
   logic               r_valid;
   logic [31:0]        r_fetch_cnt;
   logic               w_fetch_go;
   logic               w_halt_hit;

   // A fetch only happens when the output slot is empty or being drained.
   assign w_fetch_go = (r_state == RUN) && en && !redirect && (!r_valid || bus.ready);
   assign w_halt_hit = w_fetch_go && (bus.rom_data == HALT_WORD);

   assign bus.rom_addr = r_pc;
   assign bus.rom_cs   = !w_fetch_go;
   assign bus.rom_oe   = w_fetch_go;
   assign bus.instr    = r_instr;
   assign bus.instr_pc = r_instr_pc;
   assign bus.valid    = r_valid;
   assign halted       = (r_state == HALT);
   assign fetch_cnt    = r_fetch_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         IDLE: begin
            if (en) begin
               w_state_nxt = RUN;
            end
         end
         RUN: begin
            if (!en) begin
               w_state_nxt = IDLE;
            end else if (w_halt_hit) begin
               w_state_nxt = HALT;
            end
         end
         HALT: begin
            if (redirect) begin
               w_state_nxt = en ? RUN : IDLE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // Redirect flushes the pending word even if decode takes it this cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pc        <= RESET_PC;
         r_instr     <= '0;
         r_instr_pc  <= '0;
         r_valid     <= 1'b0;
         r_fetch_cnt <= '0;
      end else if (redirect) begin
         r_pc    <= redirect_pc;
         r_valid <= 1'b0;
      end else if (w_fetch_go) begin
         r_instr     <= bus.rom_data;
         r_instr_pc  <= r_pc;
         r_valid     <= 1'b1;
         r_fetch_cnt <= r_fetch_cnt + 32'd1;
         if (!w_halt_hit) begin
            r_pc <= r_pc + PC_INC;
         end
      end else if (r_valid && bus.ready) begin
         r_valid <= 1'b0;
      end
   end

endmodule : fetch_unit

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// +----------------------------------------------------------------------------+
// | Module   : tb_fetch_unit                                                   |
// | Brief    : Vector table plus scoreboard of delivered words for fetch_unit. |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_fetch_unit;
   import riscy_pkg::*;

   typedef struct {
      addr_t pc;
      word_t w;
   } exp_t;

   typedef struct {
      logic        rst;
      logic        en;
      logic        ready;
      logic        redir;
      logic [31:0] rpc;
      logic        e_valid;
      logic [31:0] e_instr;
      logic [31:0] e_ipc;
      logic [31:0] e_addr;
      logic        e_cs;
      logic [31:0] e_cnt;
   } vec_t;

   logic        clk;
   logic        rst;
   logic        en;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        halted;
   logic [31:0] fetch_cnt;
   logic [31:0] mem [0:63];

   int   n_checks;
   int   n_fail;
   exp_t exp_q[$];
   vec_t vt[16];

   fetch_unit_if #(.AWIDTH(32), .DWIDTH(32)) bus ();

   fetch_unit #(
      .AWIDTH   (32),
      .DWIDTH   (32),
      .RESET_PC (32'd0),
      .PC_INC   (32'd1),
      .HALT_WORD(32'hFFFF_FFFF)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .redirect   (redirect),
      .redirect_pc(redirect_pc),
      .bus        (bus.master),
      .halted     (halted),
      .fetch_cnt  (fetch_cnt)
   );

   // Unselected ROM returns a poison word rather than real data.
   assign bus.rom_data = !bus.rom_cs ? mem[bus.rom_addr[5:0]] : 32'hDEAD_BEEF;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input addr_t pc);
      exp_t e;
      e.pc = pc;
      e.w  = (pc[5:0] == 6'd5) ? 32'hFFFF_FFFF : 32'(pc[5:0]) + 32'd100;
      exp_q.push_back(e);
   endtask

   function automatic vec_t mk(logic r, logic e, logic rd, logic re, logic [31:0] rp,
                               logic v, logic [31:0] ins, logic [31:0] ipc,
                               logic [31:0] ad, logic cs, logic [31:0] cnt);
      vec_t x;
      x.rst = r;  x.en = e;  x.ready = rd;  x.redir = re;  x.rpc = rp;
      x.e_valid = v;  x.e_instr = ins;  x.e_ipc = ipc;
      x.e_addr = ad;  x.e_cs = cs;  x.e_cnt = cnt;
      return x;
   endfunction

   // Scoreboard: a handshake completes at the next edge unless flushed or reset.
   always @(negedge clk) begin
      if (rst === 1'b0 && bus.valid === 1'b1 && bus.ready === 1'b1 && redirect === 1'b0) begin
         if (exp_q.size() == 0) begin
            chk("sb_unexpected_pc", {32'd0, bus.instr_pc}, 64'hFFFF_FFFF_FFFF_FFFF);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("sb_instr_pc", {32'd0, bus.instr_pc}, {32'd0, e.pc});
            chk("sb_instr", {32'd0, bus.instr}, {32'd0, e.w});
         end
      end
   end

   initial begin
      int  wait_n;
      bit  seen;
      bit  cs_bad;

      n_checks = 0;
      n_fail   = 0;
      for (int k = 0; k < 64; k++) mem[k] = 32'(k) + 32'd100;
      mem[5] = 32'hFFFF_FFFF;

      //        rst en rdy red rpc | valid instr ipc  addr cs cnt
      vt[0]  = mk(1, 1, 1, 0, 0,    0, 0,   0,  0,  1, 0);
      vt[1]  = mk(0, 1, 1, 0, 0,    0, 0,   0,  0,  1, 0);
      vt[2]  = mk(0, 1, 1, 0, 0,    0, 0,   0,  0,  0, 0);
      vt[3]  = mk(0, 1, 1, 0, 0,    1, 100, 0,  1,  0, 1);
      vt[4]  = mk(0, 1, 0, 0, 0,    1, 101, 1,  2,  1, 2);
      vt[5]  = mk(0, 1, 0, 0, 0,    1, 101, 1,  2,  1, 2);
      vt[6]  = mk(0, 1, 0, 0, 0,    1, 101, 1,  2,  1, 2);
      vt[7]  = mk(0, 1, 1, 0, 0,    1, 101, 1,  2,  0, 2);
      vt[8]  = mk(0, 1, 1, 0, 0,    1, 102, 2,  3,  0, 3);
      vt[9]  = mk(0, 1, 1, 1, 40,   1, 103, 3,  4,  1, 4);
      vt[10] = mk(0, 1, 1, 0, 0,    0, 0,   0,  40, 0, 4);
      vt[11] = mk(0, 1, 1, 0, 0,    1, 140, 40, 41, 0, 5);
      vt[12] = mk(0, 0, 0, 0, 0,    1, 141, 41, 42, 1, 6);
      vt[13] = mk(0, 0, 0, 0, 0,    1, 141, 41, 42, 1, 6);
      vt[14] = mk(0, 0, 1, 0, 0,    1, 141, 41, 42, 1, 6);
      vt[15] = mk(0, 0, 1, 0, 0,    0, 0,   0,  42, 1, 6);
      push(0); push(1); push(2); push(40); push(41);

      rst = 1'b1; en = 1'b1; bus.ready = 1'b1; redirect = 1'b0; redirect_pc = '0;
      step();
      step();

      for (int i = 0; i < 16; i++) begin
         step();
         rst = vt[i].rst; en = vt[i].en; bus.ready = vt[i].ready;
         redirect = vt[i].redir; redirect_pc = vt[i].rpc;
         @(negedge clk);
         chk($sformatf("v%0d_valid", i), {63'd0, bus.valid}, {63'd0, vt[i].e_valid});
         chk($sformatf("v%0d_rom_cs", i), {63'd0, bus.rom_cs}, {63'd0, vt[i].e_cs});
         chk($sformatf("v%0d_rom_oe", i), {63'd0, bus.rom_oe}, {63'd0, !vt[i].e_cs});
         chk($sformatf("v%0d_rom_addr", i), {32'd0, bus.rom_addr}, {32'd0, vt[i].e_addr});
         chk($sformatf("v%0d_fetch_cnt", i), {32'd0, fetch_cnt}, {32'd0, vt[i].e_cnt});
         chk($sformatf("v%0d_halted", i), {63'd0, halted}, 64'd0);
         if (vt[i].e_valid) begin
            chk($sformatf("v%0d_instr", i), {32'd0, bus.instr}, {32'd0, vt[i].e_instr});
            chk($sformatf("v%0d_instr_pc", i), {32'd0, bus.instr_pc}, {32'd0, vt[i].e_ipc});
         end
      end

      // Halt: run from 3 until the halt word at 5 is captured.
      step(); en = 1'b1; bus.ready = 1'b1; redirect = 1'b1; redirect_pc = 32'd3;
      push(3); push(4); push(5);
      step(); redirect = 1'b0;
      @(negedge clk);
      chk("halt_first_addr", {32'd0, bus.rom_addr}, 64'd3);
      seen = 1'b0;
      wait_n = 0;
      while (!seen && wait_n < 20) begin
         step();
         @(negedge clk);
         seen = (halted === 1'b1);
         wait_n++;
      end
      chk("halt_reached", {63'd0, seen}, 64'd1);
      chk("halt_instr", {32'd0, bus.instr}, 64'hFFFF_FFFF);
      chk("halt_instr_pc", {32'd0, bus.instr_pc}, 64'd5);
      chk("halt_pc_held", {32'd0, bus.rom_addr}, 64'd5);
      cs_bad = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         @(negedge clk);
         if (bus.rom_cs !== 1'b1 || bus.rom_oe !== 1'b0 || halted !== 1'b1) cs_bad = 1'b1;
      end
      chk("halt_rom_idle_10", {63'd0, cs_bad}, 64'd0);

      step(); redirect = 1'b1; redirect_pc = 32'd0;
      push(0); push(1);
      @(negedge clk);
      chk("halt_before_exit", {63'd0, halted}, 64'd1);
      step(); redirect = 1'b0;
      @(negedge clk);
      chk("halt_exit", {63'd0, halted}, 64'd0);
      chk("restart_cs", {63'd0, bus.rom_cs}, 64'd0);
      chk("restart_addr", {32'd0, bus.rom_addr}, 64'd0);
      step();
      step(); en = 1'b0;
      @(negedge clk);
      chk("restart_instr", {32'd0, bus.instr}, 64'd101);
      step();
      @(negedge clk);
      chk("restart_drained", {63'd0, bus.valid}, 64'd0);

      // PC wrap at the top of the address space.
      step(); en = 1'b1; redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF;
      push(32'hFFFF_FFFF); push(0);
      step(); redirect = 1'b0;
      @(negedge clk);
      chk("wrap_addr_max", {32'd0, bus.rom_addr}, 64'hFFFF_FFFF);
      chk("wrap_cs", {63'd0, bus.rom_cs}, 64'd0);
      step();
      @(negedge clk);
      chk("wrap_addr_zero", {32'd0, bus.rom_addr}, 64'd0);
      chk("wrap_instr_pc", {32'd0, bus.instr_pc}, 64'hFFFF_FFFF);
      step(); en = 1'b0;
      @(negedge clk);
      chk("wrap_next_addr", {32'd0, bus.rom_addr}, 64'd1);
      step();

      // Reset in the middle of a stall.
      step(); en = 1'b1; bus.ready = 1'b0;
      step();
      step();
      @(negedge clk);
      chk("stall_valid", {63'd0, bus.valid}, 64'd1);
      chk("stall_instr", {32'd0, bus.instr}, 64'd101);
      chk("stall_cs", {63'd0, bus.rom_cs}, 64'd1);
      step(); rst = 1'b1;
      step(); rst = 1'b0; en = 1'b0;
      @(negedge clk);
      chk("rst_valid", {63'd0, bus.valid}, 64'd0);
      chk("rst_pc", {32'd0, bus.rom_addr}, 64'd0);
      chk("rst_cnt", {32'd0, fetch_cnt}, 64'd0);
      chk("rst_instr", {32'd0, bus.instr}, 64'd0);
      chk("rst_instr_pc", {32'd0, bus.instr_pc}, 64'd0);
      chk("rst_halted", {63'd0, halted}, 64'd0);
      chk("rst_cs", {63'd0, bus.rom_cs}, 64'd1);
      step();
      @(negedge clk);
      chk("rst_state_idle", {63'd0, bus.rom_cs}, 64'd1);

      chk("sb_queue_empty", 64'(exp_q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule : tb_fetch_unit

`default_nettype wire

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage that sits directly upstream of the program ROM. It owns the program counter and drives the ROM's address, active-low chip select and output enable. It registers the returned word and presents it to decode through a valid/ready handshake. It supports stall, branch/jump redirect, fetch enable and halt detection.

Parameters:
AWIDTH, 32, ROM address / PC width
DWIDTH, 32, instruction word width (matches ROM data width)
RESET_PC, 0, PC value loaded on reset
PC_INC, 1, PC increment per fetch (ROM is word-addressed)
HALT_WORD, 32'hFFFF_FFFF, fetched word that halts fetching

Ports:
CLK  input  1  clock, all state on rising edge
RST  input  1  synchronous, active-high reset
EN  input  1  fetch enable
REDIRECT  input  1  branch/jump taken; load REDIRECT_PC
REDIRECT_PC  input  AWIDTH  redirect target
ROM_ADDR  output  AWIDTH  ROM address (equals PC register)
ROM_CS  output  1  ROM chip select, active low
ROM_OE  output  1  ROM output enable, active high
ROM_DATA  input  DWIDTH  ROM read data (combinational, high-Z when not selected)
INSTR  output  DWIDTH  registered instruction to decode
INSTR_PC  output  AWIDTH  address INSTR was fetched from
VALID  output  1  INSTR/INSTR_PC valid
READY  input  1  decode accepts INSTR this cycle
HALTED  output  1  high while FSM is in HALT
FETCH_CNT  output  32  count of fetches performed, wraps

Behaviour:
- Reset (RST=1 at an edge, which overrides everything including a mid-stall or mid-redirect): PC=RESET_PC, state=IDLE, VALID=0, INSTR=0, INSTR_PC=0, FETCH_CNT=0.
- FSM states and transitions:
  - IDLE -> RUN when EN=1.
  - RUN -> IDLE when EN=0.
  - RUN -> HALT when a fetch captures HALT_WORD.
  - HALT -> RUN on REDIRECT=1 with EN=1.
  - HALT -> IDLE on REDIRECT=1 with EN=0.
- Fetch condition: fetch_go = (state==RUN) && EN && !REDIRECT && (!VALID || READY).
- ROM interface, combinational from registers:
  - ROM_ADDR = PC at all times.
  - ROM_CS = !fetch_go.
  - ROM_OE = fetch_go.
  - The ROM is never selected while stalled, idle or halted.
- On fetch_go at an edge:
  - INSTR <= ROM_DATA, INSTR_PC <= PC, VALID <= 1, FETCH_CNT++.
  - PC <= PC + PC_INC, modulo 2^AWIDTH; PC wraps from max to 0 silently.
- Halt on fetch: if ROM_DATA == HALT_WORD on a fetch, the word is still delivered with VALID=1 and PC is NOT incremented.
- Consume with no new fetch: VALID && READY && !fetch_go -> VALID <= 0.
- Stall: VALID && !READY -> INSTR, INSTR_PC and PC hold; no fetch.
- Throughput and latency:
  - One instruction per cycle while READY=1.
  - First VALID appears 1 cycle after the first cycle in RUN.
- REDIRECT has the highest priority below RST, in any state:
  - PC <= REDIRECT_PC and VALID <= 0. A pending, unconsumed instruction is flushed, including when READY=1 in the same cycle.
  - No fetch occurs in the redirect cycle.
  - The fetch from REDIRECT_PC occurs the next cycle, giving exactly one bubble. In IDLE, REDIRECT updates PC only.
- EN=0 while VALID=1: the held instruction remains valid until consumed or flushed.
- HALTED = (state==HALT).

Decomposition:
- Shared package riscy_pkg:
  - fetch_state_t enum {IDLE, RUN, HALT}
  - default HALT_WORD constant
  - addr_t / word_t typedefs sized 32
- No sub-module needed. The PC register plus output register are small; keep them in one module.

Test Plan:
- Reset with EN=1, READY=1, ROM preloaded with words k+100 at addr k -> ROM_CS high during reset; then ROM_ADDR 0,1,2,3; INSTR 100,101,102 on consecutive cycles with INSTR_PC 0,1,2; FETCH_CNT=3.
- READY low for 3 cycles while VALID=1 (INSTR=101) -> INSTR/INSTR_PC/PC held, ROM_CS=1, ROM_OE=0; on READY=1 the stream resumes with 102 with no loss or duplicate.
- REDIRECT=1, REDIRECT_PC=40 while VALID=1 and READY=1 -> next cycle VALID=0 (one bubble); following cycle INSTR=140, INSTR_PC=40.
- ROM addr 5 holds HALT_WORD -> INSTR=HALT_WORD delivered with INSTR_PC=5, HALTED=1, no further ROM_CS assertion for 10 cycles; REDIRECT to 0 -> HALTED=0, fetch restarts at 0.
- PC at 2^AWIDTH-1 (via REDIRECT) -> fetch there, next ROM_ADDR=0.
- RST asserted during a stall with VALID=1 -> next cycle VALID=0, PC=RESET_PC, state IDLE, FETCH_CNT=0.
